// File: rtl/prbs10_checker.sv
// Self-synchronising checker for a 10-bit Fibonacci PRBS word stream.
// Hunts for alignment, locks after LOCK_CNT predicted words, then counts word errors.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_HUNT   | waiting for a nonzero word to seed the local replica
// ST_VERIFY | replica seeded; counting consecutive correct predictions
// ST_LOCKED | aligned; replica free-runs and mismatches are counted
module prbs10_checker #(
    parameter int TAP_A    = 9,
    parameter int TAP_B    = 8,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [9:0]       in_data,
    input  logic             clear_cnt,
    output logic             locked,
    output logic [1:0]       state,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             err_sat,
    output logic             zero_det
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);
    localparam logic [3:0]       LOSS_C  = 4'(LOSS_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t           state_q, state_d;
    logic [9:0]       expected_q, expected_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [3:0]       miss_cnt_q, miss_cnt_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic             zero_det_q, zero_det_d;
    logic             err_sat_q, err_sat_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic             word_match;
    logic             word_zero;
    logic [3:0]       match_inc;
    logic [3:0]       miss_inc;

    function automatic logic [9:0] step(input logic [9:0] x);
        return {x[8:0], x[TAP_A] ^ x[TAP_B]};
    endfunction

    assign word_match = (in_data == expected_q);
    assign word_zero  = (in_data == 10'd0);
    assign match_inc  = match_cnt_q + 4'd1;
    assign miss_inc   = miss_cnt_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_count_d = err_count_q;
        err_sat_d   = err_sat_q;
        err_pulse_d = 1'b0;
        zero_det_d  = 1'b0;

        if (in_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (word_zero) begin
                        zero_det_d = 1'b1;
                    end else begin
                        expected_d  = step(in_data);
                        match_cnt_d = 4'd0;
                        state_d     = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (word_match) begin
                        match_cnt_d = match_inc;
                        expected_d  = step(in_data);
                        if (match_inc == LOCK_C) begin
                            state_d    = ST_LOCKED;
                            miss_cnt_d = 4'd0;
                        end
                    end else if (!word_zero) begin
                        expected_d  = step(in_data);
                        match_cnt_d = 4'd0;
                    end else begin
                        zero_det_d = 1'b1;
                        state_d    = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    // Replica advances from itself, never from the received word.
                    expected_d = step(expected_q);
                    zero_det_d = word_zero;
                    if (word_match) begin
                        miss_cnt_d = 4'd0;
                    end else begin
                        err_pulse_d = 1'b1;
                        miss_cnt_d  = miss_inc;
                        if (err_count_q != ERR_MAX) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (miss_inc == LOSS_C) begin
                            state_d = ST_HUNT;
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end

        err_sat_d = err_sat_q | (err_count_d == ERR_MAX);
        if (clear_cnt) begin
            err_count_d = '0;
            err_sat_d   = 1'b0;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            expected_q  <= 10'd0;
            match_cnt_q <= 4'd0;
            miss_cnt_q  <= 4'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            zero_det_q  <= 1'b0;
            err_count_q <= '0;
            err_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            zero_det_q  <= zero_det_d;
            err_count_q <= err_count_d;
            err_sat_q   <= err_sat_d;
        end
    end

    assign state     = state_q;
    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign err_sat   = err_sat_q;
    assign zero_det  = zero_det_q;

endmodule

// File: doc/prbs10_checker.md
Name: prbs10_checker

Overview:
- Self-synchronising checker for the 10-bit Fibonacci PRBS word stream produced by the team's LFSR generator.
- Step function: next = {cur[8:0], cur[TAP_A]^cur[TAP_B]}.
- Sits directly downstream of the generator, or after a loopback path. Hunts for sequence alignment, declares lock, then counts word errors against a free-running local replica.
- Used for on-chip BIST of the generator and of loopback paths.

Parameters:
- TAP_A, 9, first feedback tap index.
- TAP_B, 8, second feedback tap index.
- LOCK_CNT, 4, consecutive correctly predicted words required to declare lock (range 1..15).
- LOSS_CNT, 3, consecutive mismatching words in LOCKED that force return to HUNT (range 1..15).
- ERR_W, 16, error counter width.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, synchronous, active-high reset.
- in_valid, input, 1, in_data carries a new word this cycle.
- in_data, input, 10, received PRBS word.
- clear_cnt, input, 1, synchronous clear of err_count and err_sat.
- locked, output, 1, high while in LOCKED.
- state, output, 2, 0=HUNT, 1=VERIFY, 2=LOCKED (3 unused).
- err_pulse, output, 1, one-cycle pulse for each mismatching word in LOCKED.
- err_count, output, ERR_W, saturating count of mismatching words while LOCKED.
- err_sat, output, 1, sticky flag: err_count reached all-ones.
- zero_det, output, 1, one-cycle pulse when a valid all-zero word arrives (illegal lock-up state).

Behaviour:
- Registered outputs: all outputs come from flops. Each response appears the cycle after the in_valid edge that caused it.
- Reset: state=HUNT, locked=0, err_pulse=0, err_count=0, err_sat=0, zero_det=0. Internal state cleared: expected=0, match_cnt=0, miss_cnt=0.
- Mid-operation reset: rst wins over all other inputs; all state returns to reset values on that edge.
- in_valid=0: no state, counter or expected-word change; pulse outputs go low.
- step(x) = {x[8:0], x[TAP_A]^x[TAP_B]}.
- HUNT, on valid word:
  - in_data==0 -> zero_det pulse, stay in HUNT.
  - in_data!=0 -> expected<=step(in_data), match_cnt<=0, go to VERIFY.
- VERIFY, on valid word:
  - in_data==expected -> match_cnt+1; expected<=step(in_data). If match_cnt+1==LOCK_CNT, go to LOCKED with miss_cnt<=0.
  - Mismatch, nonzero word -> reseed: expected<=step(in_data), match_cnt<=0, stay in VERIFY.
  - Mismatch, zero word -> zero_det pulse, go to HUNT.
  - No error counting in VERIFY.
- LOCKED, on valid word:
  - expected<=step(expected) regardless of result. The replica free-runs, so one corrupted word gives exactly one error.
  - Match -> miss_cnt<=0.
  - Mismatch -> err_pulse=1; err_count+1, saturating at 2^ERR_W-1, at which err_sat sets and stays set; miss_cnt+1.
  - If miss_cnt+1==LOSS_CNT -> go to HUNT, locked=0. The error for that word is still counted.
  - A zero word in LOCKED is an ordinary mismatch and also pulses zero_det.
- Lock latency: LOCK_CNT+1 valid words (1 seed + LOCK_CNT matches). locked rises the cycle after the edge sampling the last match.
- clear_cnt:
  - Zeroes err_count and err_sat.
  - Takes priority over a simultaneous increment; result is 0, but err_pulse still fires.
  - Does not affect state, miss_cnt or expected.
- Gaps: in_valid may deassert for any number of cycles in any state. Prediction advances only per valid word.

Test Plan:
- Lock: rst, then valid words 0x001,0x002,0x004,0x008,0x010 (LOCK_CNT=4). Expect state 0->1, locked=1 the cycle after 0x010, err_count=0.
- Single error: locked stream continues 0x020,0x040,0x0C0(bad, expected 0x080),0x100,0x201,0x003. Expect exactly one err_pulse (cycle after 0x0C0), err_count=1, lock held.
- Loss of lock: while locked, feed 3 consecutive wrong words. Expect err_count+3, three err_pulses, locked=0 and state=HUNT after the third.
- Zero/reseed: in HUNT feed 0x000. Expect zero_det pulse, stay HUNT. Then feed 0x100, 0x201, 0x155(bad). Expect reseed in VERIFY, no err_count change. Then feed step(0x155)... x4. Expect lock.
- Gaps/clear: lock with in_valid toggling every other cycle. Expect same result as contiguous. Assert clear_cnt on the same cycle as an error. Expect err_pulse=1, err_count=0.
- Saturation/reset: ERR_W=3, force 9 errors while keeping lock (alternate bad/good words). Expect err_count=7, err_sat=1. Assert rst mid-stream. Expect all outputs at reset values next cycle.
